// File: rtl/regfile_mbox.sv
// Parametrised two-read/one-write register file with pixel mailbox and output register.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mbox #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int PIX_W    = 12,
  parameter int IMG_REG  = 12,
  parameter int WTR_REG  = 13,
  parameter int OUT_REG  = 14,
  parameter int DONE_REG = 15,
  parameter int STAT_REG = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  img_pix,
  input  logic [PIX_W-1:0]  wtr_pix,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_pix,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(STAT_REG);
  localparam logic [ADDR_W-1:0] OUT_A  = ADDR_W'(OUT_REG);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              full;
  logic              overrun;
  logic              capture;
  logic              wr_stat;
  logic              wr_out;
  logic              accept;
  logic [DATA_W-1:0] stat_val;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // The input side is a depth-1 mailbox released by software (W1C of STAT bit0);
  // the output side holds out_pix stable while out_valid=1 until out_ready accepts it.
  assign in_ready = !full;
  assign capture  = in_valid && !full;
  assign wr_stat  = we && (waddr == STAT_A);
  assign wr_out   = we && (waddr == OUT_A);
  assign accept   = out_valid && out_ready;
  assign stat_val = DATA_W'({overrun, full});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      // Register 0 and the status slot are never written into the array.
      for (int i = 1; i < DEPTH; i++) begin
        if (capture && i == IMG_REG)
          regs[i] <= DATA_W'(img_pix);
        else if (capture && i == WTR_REG)
          regs[i] <= DATA_W'(wtr_pix);
        else if (we && waddr == ADDR_W'(i) && i != STAT_REG)
          regs[i] <= wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= 1'b0;
      overrun   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (capture)
        full <= 1'b1;
      else if (wr_stat && wdata[0])
        full <= 1'b0;

      // An accept in the same cycle as a new write frees the slot, so no overrun.
      if (wr_out && out_valid && !out_ready)
        overrun <= 1'b1;
      else if (wr_stat && wdata[1])
        overrun <= 1'b0;

      if (wr_out)
        out_valid <= 1'b1;
      else if (accept)
        out_valid <= 1'b0;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    if (a == '0)
      v = '0;
    else if (a == STAT_A)
      v = stat_val;
    else
      v = regs[a];
`ifdef REGFILE_BYPASS_EN
    if (we && a == waddr && a != '0 && a != STAT_A)
      v = wdata;
`endif
    return v;
  endfunction

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    rdata1 = read_port(raddr1);
    rdata2 = read_port(raddr2);
  end

  assign out_pix = regs[OUT_REG][PIX_W-1:0];
  assign done    = regs[DONE_REG][0];

endmodule

// File: doc/regfile_mbox.md
# regfile_mbox

Parametrised register file for the soft watermark processor, succeeding the fixed 32x32 file. It provides two combinational read ports and one write port, with an optional write-to-read bypass. Register 0 is hardwired to zero. Memory-mapped registers exchange pixels with the VGA and image path over valid/ready handshakes instead of overwriting registers every cycle.

## Interface
Parameters:
- DATA_W, default 32: register width.
- ADDR_W, default 5: address width; depth is 2**ADDR_W.
- PIX_W, default 12: pixel width (RGB 4:4:4). Must satisfy PIX_W ≤ DATA_W.
- IMG_REG, default 12: image pixel mailbox register.
- WTR_REG, default 13: watermark pixel mailbox register.
- OUT_REG, default 14: output pixel register.
- DONE_REG, default 15: software done flag, bit 0.
- STAT_REG, default 22: status register; bit0 = mailbox full, bit1 = output overrun.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- raddr1, raddr2  in  ADDR_W  read addresses.
- rdata1, rdata2  out  DATA_W  read data, combinational.
- in_valid  in  1  input pixel pair valid.
- in_ready  out  1  mailbox empty; equals !full.
- img_pix, wtr_pix  in  PIX_W  image pixel and watermark pixel.
- out_valid  out  1  output pixel pending.
- out_ready  in  1  VGA side accepts the output pixel.
- out_pix  out  PIX_W  equals OUT_REG[PIX_W-1:0].
- done  out  1  equals DONE_REG[0], registered.

## Operation
- Reset: every register is 0, including full, overrun and out_valid. Consequently in_ready=1, out_valid=0, done=0 and out_pix=0. Software loads its own constants.
- Register 0 reads as 0; writes to it are ignored.
- Plain registers: on the clock edge with we=1, the register at waddr takes wdata.
- Mailbox capture: when in_valid && in_ready, IMG_REG takes {0, img_pix}, WTR_REG takes {0, wtr_pix} (both zero-extended), and full is set.
- Capture collisions: if a capture and a software write to IMG_REG or WTR_REG happen in the same cycle, the capture wins.
- STAT_REG reads as {0, overrun, full}.
- STAT_REG writes are write-1-to-clear:
  - wdata[0]=1 clears full, releasing the mailbox.
  - wdata[1]=1 clears overrun.
  - Other bits are ignored.
- Output write: a write to OUT_REG stores wdata and sets out_valid.
  - If out_valid=1 and out_ready=0 in that cycle, overrun is set and the new data replaces the old.
- Output accept: out_valid && out_ready clears out_valid, unless OUT_REG is written in the same cycle; then the old value is taken, out_valid stays 1 and overrun is not set.
- The done output follows DONE_REG[0] one cycle after the write.

## Timing
- Read latency is 0 (combinational). A write becomes visible on the read ports in the following cycle.
- in_ready deasserts in the cycle after a capture. It reasserts in the cycle after a STAT_REG write with wdata[0]=1.
- out_valid asserts in the cycle after an OUT_REG write.
- Back-to-back rate: one pixel pair per software release. There is no internal queue; depth is 1.
- Reset asserted mid-transfer: all state clears asynchronously and the pending pixel is dropped. Handshake outputs are valid on the first edge after rst_n rises.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If we=1 and raddrN==waddr, rdataN returns wdata in the same cycle.
  - This does not apply to register 0 or STAT_REG.
  - IMG_REG and WTR_REG bypass wdata even when a capture collides in the same cycle.
- REGFILE_BYPASS_EN undefined: reads always return the current stored value.

## Test plan
- Reset check: assert rst_n=0 mid-run after writing 0xDEADBEEF to r5. Required: r5=0, in_ready=1, out_valid=0, done=0.
- Register 0: write 0x1234 to r0. Required: r0 reads 0. Write 0xA5A5A5A5 to r31. Required: r31 reads 0xA5A5A5A5 on both ports the next cycle.
- Mailbox:
  - Drive in_valid=1 with img=0xABC and wtr=0x123. Required: r12=0x00000ABC, r13=0x00000123, STAT=0x1, in_ready=0.
  - Then drive a second pixel pair. Required: it is ignored.
  - Write STAT=0x1. Required: in_ready=1 the next cycle.
- Output path:
  - With out_ready=0, write 0xF00 then 0x0F0 to r14. Required: out_pix=0x0F0, STAT bit1=1.
  - Raise out_ready. Required: out_valid=0 one cycle later.
  - Write STAT=0x2. Required: overrun clears.
- Simultaneous accept and write: out_valid=1 (pixel 0x111), out_ready=1, and in the same cycle a write of 0x222 to r14. Required: 0x111 is accepted, out_valid stays 1, out_pix=0x222, overrun=0.
- Bypass with REGFILE_BYPASS_EN defined: write 0x55 to r8 with raddr1=8. Required: rdata1=0x55 in the same cycle. Without the macro, rdata1 shows the old value that cycle.
